instr_loader: RTL

- Front-end stage directly upstream of the bit-serial CPU core.
- Synchronizes and debounces the user push-button and produces the one-cycle `btn_edge` pulse.
- Assembles a 16-bit instruction word from two 8-bit switch bytes, one byte per button press.
- Presents `opcode[3:0]` and `instr[11:0]` to the core, with a one-cycle `inst_done` pulse when a complete word is issued.

---
 rtl/instr_loader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// Push-button debouncer and two-byte instruction assembler feeding the bit-serial core.
// Optional WAIT_HI inactivity timeout enabled by defining LOADER_TIMEOUT_EN.
module instr_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
`ifdef LOADER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw_in,
  input  logic       btn_raw,
  input  logic       core_ready,
  output logic [3:0] opcode,
  output logic [11:0] instr,
  output logic       inst_done,
  output logic       btn_edge,
  output logic       phase,
  output logic       dropped
`ifdef LOADER_TIMEOUT_EN
  , output logic     timeout
`endif
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {WAIT_LO, WAIT_HI, PEND} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s1_d, s2_q, s2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_edge_q, btn_edge_d;
  logic [7:0]       lo_q, lo_d, hi_q, hi_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [11:0]      instr_q, instr_d;
  logic             inst_done_q, inst_done_d;
  logic             phase_q, phase_d;
  logic             dropped_q, dropped_d;
`ifdef LOADER_TIMEOUT_EN
  logic [TMO_W-1:0] tcnt_q, tcnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Synchronizer, debouncer (any bounce restarts the count) and press pulse.
  always_comb begin
    s1_d       = btn_raw;
    s2_d       = s1_q;
    stable_d   = stable_q;
    cnt_d      = '0;
    btn_edge_d = 1'b0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d   = s2_q;
        btn_edge_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Loader FSM next-state and registered outputs.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    opcode_d    = opcode_q;
    instr_d     = instr_q;
    inst_done_d = 1'b0;
    dropped_d   = dropped_q;
`ifdef LOADER_TIMEOUT_EN
    tcnt_d      = tcnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      WAIT_LO: begin
        if (btn_edge_q) begin
          lo_d    = sw_in;
          state_d = WAIT_HI;
`ifdef LOADER_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end
      WAIT_HI: begin
        if (btn_edge_q) begin
          hi_d    = sw_in;
          state_d = PEND;
`ifdef LOADER_TIMEOUT_EN
          tcnt_d  = '0;
        end else if (tcnt_q == TMO_LAST) begin
          lo_d      = '0;
          state_d   = WAIT_LO;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TMO_W'(1);
`endif
        end
      end
      PEND: begin
        if (core_ready) begin
          opcode_d    = hi_q[7:4];
          instr_d     = {hi_q[3:0], lo_q};
          inst_done_d = 1'b1;
          state_d     = WAIT_LO;
        end else if (btn_edge_q) begin
          dropped_d = 1'b1;
        end
      end
      default: state_d = WAIT_LO;
    endcase
    phase_d = (state_d != WAIT_LO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_LO;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      stable_q    <= 1'b0;
      cnt_q       <= '0;
      btn_edge_q  <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      opcode_q    <= '0;
      instr_q     <= '0;
      inst_done_q <= 1'b0;
      phase_q     <= 1'b0;
      dropped_q   <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      tcnt_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      btn_edge_q  <= btn_edge_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      opcode_q    <= opcode_d;
      instr_q     <= instr_d;
      inst_done_q <= inst_done_d;
      phase_q     <= phase_d;
      dropped_q   <= dropped_d;
`ifdef LOADER_TIMEOUT_EN
      tcnt_q      <= tcnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign opcode    = opcode_q;
  assign instr     = instr_q;
  assign inst_done = inst_done_q;
  assign btn_edge  = btn_edge_q;
  assign phase     = phase_q;
  assign dropped   = dropped_q;
`ifdef LOADER_TIMEOUT_EN
  assign timeout   = timeout_q;
`endif

endmodule
